dic_ram_arbiter: RTL
====================

# dic_ram_arbiter

Round-robin arbiter that shares the single-port LZW dictionary RAM between three requesters: the dictionary search path, the string writer, and the output-buffer reader. It sits between the microprogrammed controller's datapath and the RAM macro. It grants at most one access per cycle and returns read data one cycle after the grant. It also contains an optional hardware sweep that zero-fills the dictionary on command.

## Interface
- `AddressSize`, default 8: RAM address width; the dictionary holds 2^AddressSize words.
- `DataWidth`, default 8: RAM word width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req` input 3: access request per requester. Bit 0 = search, bit 1 = string writer, bit 2 = output buffer.
- `we` input 3: per requester, 1 = write, 0 = read. Valid while the matching `req` bit is high.
- `addr` input 3*AddressSize: packed addresses; requester i uses slice [i*AddressSize +: AddressSize].
- `wdata` input 3*DataWidth: packed write data, same slicing as `addr`.
- `gnt` output 3: one-hot, combinational; access accepted this cycle.
- `rvalid` output 3: registered; `rdata` is valid for that requester.
- `rdata` output DataWidth: shared read data, passed through from `ram_rdata`.
- `ram_addr` output AddressSize: RAM address.
- `ram_we` output 1: RAM write enable.
- `ram_wdata` output DataWidth: RAM write data.
- `ram_rdata` input DataWidth: RAM synchronous read data, valid the cycle after the address is presented.
- `init_start` input 1: single-cycle pulse that starts the zero-fill sweep.
- `init_busy` output 1: sweep in progress.
- `init_done` output 1: single-cycle pulse on the last sweep write.

## Operation
- States: RUN and INIT. Reset state is RUN.
- **RUN arbitration:**
  - 2-bit pointer `ptr` takes values 0..2 and resets to 0.
  - Search order is ptr, ptr+1, ptr+2 (mod 3).
  - The first requester in that order with `req` high wins and its `gnt` bit is asserted.
- **RAM drive:** the winner's `addr`, `we` and `wdata` drive the RAM ports in the same cycle.
  - With no winner: `ram_we`=0 and `ram_addr`/`ram_wdata` hold their last value.
- **Pointer update:** after a grant to k, `ptr` <= (k+1) mod 3. With no grant, `ptr` is unchanged.
- **Read return:** a granted read sets `rvalid[k]` for exactly one cycle, the next cycle. A granted write never sets `rvalid`.
- **Requester rule:**
  - Hold `req`/`addr`/`we`/`wdata` stable until `gnt` is seen.
  - `req` may stay high for back-to-back accesses.
  - `gnt` is not a credit; an ungranted request simply waits.
- **Fairness:** with all three requesting continuously, grants rotate 0,1,2,0,… Worst-case wait is 2 cycles.
- **INIT state** (only with the macro defined):
  - Entered from RUN when `init_start`=1. The requests of that cycle are not granted.
  - `init_busy`=1 throughout; `gnt`=0 for all requesters; requests remain pending.
  - An internal counter writes 0 to addresses 0 .. 2^AddressSize-1, one per cycle, with `ram_we`=1.
  - On the write to the last address, `init_done` pulses and the state returns to RUN next cycle with `ptr` unchanged.
  - `init_start` is ignored while in INIT.
- **Reset:** reset mid-sweep aborts it. The state returns to RUN with the counter at 0; no `init_done` is produced.

## Timing
- Grant latency: 0 cycles (combinational `gnt`, asserted the same cycle as `req` when the requester wins).
- Read latency: `rvalid`/`rdata` are valid exactly 1 cycle after the `gnt` cycle.
- Throughput: one RAM access per cycle in aggregate.
- Read-after-write: a read granted in the cycle after a write to the same address returns the new data.
- Sweep duration: 2^AddressSize cycles of `init_busy` (256 at defaults). `init_done` coincides with the last busy cycle.
- Reset values:
  - `gnt`=0 (forced low while `reset`=1), `rvalid`=0, `ram_we`=0.
  - `ram_addr`=0, `ram_wdata`=0, `init_busy`=0, `init_done`=0.
  - `ptr`=0, state RUN.
- Reset asserted in the cycle after a read grant suppresses that `rvalid`.

## Configuration
- `DIC_ARB_INIT_EN`, defined: the INIT state, sweep counter and `init_start` handling are compiled in.
- Undefined:
  - `init_start` is ignored; `init_busy` and `init_done` are tied 0.
  - Only RUN exists; the controller must zero the RAM through the string-writer port.

## Test plan
- Single read: `req`=3'b001, `we`=0, `addr[7:0]`=8'h2A, RAM holding 8'h5C at 8'h2A -> `gnt`=3'b001 same cycle; next cycle `rvalid`=3'b001, `rdata`=8'h5C.
- Round-robin: `req`=3'b111 held for 6 cycles from reset -> `gnt` sequence 001,010,100,001,010,100.
- Write then read: requester 1 writes 8'hA7 to 8'h10, then requester 0 reads 8'h10 next cycle -> `rvalid[0]`, `rdata`=8'hA7; no `rvalid[1]` pulse.
- Sweep (macro on): pulse `init_start` with `req`=3'b100 pending -> 256 busy cycles, `gnt`=0 throughout, `init_done` pulse at address 8'hFF; next cycle `gnt`=3'b100; any address then reads 0.
- Reset mid-sweep: assert `reset` at sweep cycle 40 -> next cycle `init_busy`=0, `ram_we`=0, `ptr`=0, no `init_done`.
- Macro off: pulse `init_start` with `req`=3'b010 -> `gnt`=3'b010 same cycle, `init_busy` stays 0.

Source files
------------

// File: rtl/dic_ram_arbiter.sv
// dic_ram_arbiter: round-robin share of the LZW dictionary RAM among search, string writer and output buffer.
// Optional zero-fill sweep is compiled in with DIC_ARB_INIT_EN.
module dic_ram_arbiter #(
   parameter int AddressSize = 8,
   parameter int DataWidth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [2:0]               req,
   input  logic [2:0]               we,
   input  logic [3*AddressSize-1:0] addr,
   input  logic [3*DataWidth-1:0]   wdata,
   output logic [2:0]               gnt,
   output logic [2:0]               rvalid,
   output logic [DataWidth-1:0]     rdata,
   output logic [AddressSize-1:0]   ram_addr,
   output logic                     ram_we,
   output logic [DataWidth-1:0]     ram_wdata,
   input  logic [DataWidth-1:0]     ram_rdata,
   input  logic                     init_start,
   output logic                     init_busy,
   output logic                     init_done
);
   logic [AddressSize-1:0] reqAddr [3];
   logic [DataWidth-1:0] reqData [3];
   logic [1:0] ptr, p1, p2, k;
   logic win, grant, busy, startNow;
   logic [AddressSize-1:0] cnt, lastAddr;
   logic [DataWidth-1:0] lastData;
   logic [2:0] rvalidQ;

   for (genvar g = 0; g < 3; g++) begin : gUnpack
      assign reqAddr[g] = addr[g*AddressSize +: AddressSize];
      assign reqData[g] = wdata[g*DataWidth +: DataWidth];
   end

`ifdef DIC_ARB_INIT_EN
   typedef enum logic {RUN, INIT} stateE;
   stateE state;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt <= '0;
      end else if (state == RUN) begin
         state <= init_start ? INIT : RUN;
      end else begin
         cnt <= cnt + 1'b1;
         if (&cnt) state <= RUN;
      end
   end
   assign busy = ~reset & (state == INIT);
   assign startNow = ~reset & (state == RUN) & init_start;
`else
   logic unusedInitStart;
   assign unusedInitStart = init_start;
   assign cnt = '0;
   assign busy = 1'b0;
   assign startNow = 1'b0;
`endif

   always_comb begin
      p1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      p2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
      win = req[ptr] | req[p1] | req[p2];
      k = req[ptr] ? ptr : req[p1] ? p1 : p2;
      grant = win & ~reset & ~busy & ~startNow;
      gnt = grant ? 3'b001 << k : 3'b000;
      ram_we = busy | (grant & we[k]);
      ram_addr = reset ? '0 : busy ? cnt : grant ? reqAddr[k] : lastAddr;
      ram_wdata = (reset | busy) ? '0 : grant ? reqData[k] : lastData;
   end

   // Idle cycles keep the RAM address/data buses at whatever was last driven.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= 2'd0;
         rvalidQ <= '0;
         lastAddr <= '0;
         lastData <= '0;
      end else begin
         if (grant) ptr <= (k == 2'd2) ? 2'd0 : k + 2'd1;
         rvalidQ <= gnt & ~we;
         lastAddr <= ram_addr;
         lastData <= ram_wdata;
      end
   end

   assign rvalid = rvalidQ & {3{~reset}};
   assign rdata = ram_rdata;
   assign init_busy = busy;
   assign init_done = busy & (&cnt);
endmodule
